restoring_divider_8_bit: RTL and testbench
==========================================

Name: restoring_divider_8_bit

Overview:
Sequential unsigned restoring divider. It is the inverse companion of the lab's shift-add multiplier datapath and is built around the same 9-bit subtract-and-select step. Operands are latched on a Run request, and the block computes one quotient bit per clock with constant latency. It then presents quotient and remainder with a Done handshake on the same switch/button style interface as the multiplier top level.

Parameters:
WIDTH, 8, operand/result width; the partial remainder is WIDTH+1 bits and the iteration count equals WIDTH.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high; sampled on the Clk rising edge.
Run  input  1  level request; sampled in IDLE to start an operation.
Dividend  input  WIDTH  unsigned dividend; sampled only at the start edge.
Divisor  input  WIDTH  unsigned divisor; sampled only at the start edge.
Quotient  output  WIDTH  registered result quotient.
Remainder  output  WIDTH  registered result remainder.
Busy  output  1  high while iterating.
Done  output  1  high while in DONE.
Div_By_Zero  output  1  high in DONE if the latched Divisor was 0.

Behaviour:
- Reset (synchronous, high) -> state IDLE. Quotient, Remainder, Busy, Done, Div_By_Zero, internal R/Q/D/count all 0.
- Reset has priority over every other event. If asserted mid-ITER, the next edge enters IDLE with everything cleared, and the partial result is discarded.
- States: IDLE, ITER, DONE. Encoding is a package enum.
- IDLE: on an edge with Run=1:
  - latch D<=Divisor, Q<=Dividend, R<=0 (WIDTH+1 bits), count<=0;
  - latch dz<=(Divisor==0);
  - go to ITER, Busy<=1.
  - With Run=0 the state holds and outputs keep their last result.
- ITER, each edge:
  - form S = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits);
  - T = S - {1'b0, D}, computed as S + ~{0,D} + 1, i.e. 9-bit add with invert and carry-in 1;
  - if T[WIDTH]==0 then R<=T, qbit=1; else R<=S, qbit=0;
  - Q<={Q[WIDTH-2:0], qbit}; count<=count+1.
- On the edge where count==WIDTH-1, after performing the iteration:
  - Quotient<=new Q, Remainder<=new R[WIDTH-1:0], Div_By_Zero<=dz;
  - Busy<=0, Done<=1, state DONE.
- Latency: Done rises exactly WIDTH+1 rising edges after the start edge, counting the start edge (9 for WIDTH=8). Latency is identical for every operand pair, including divisor 0.
- Divisor 0: there is no special datapath. The restoring step naturally yields Quotient=all ones and Remainder=Dividend. Div_By_Zero=1 flags it.
- Run and operand changes during ITER are ignored.
- DONE: holds while Run=1, with no auto-restart. On an edge with Run=0 -> IDLE, Done<=0.
- Result outputs are not cleared on leaving DONE. Div_By_Zero holds until the next completion or a reset.
- Busy and Done are never high simultaneously. Quotient/Remainder change only on the completion edge or on reset.
- Invariant at completion: Dividend == Quotient*Divisor + Remainder, and Remainder < Divisor when Divisor != 0.

Decomposition:
- Shared package (divider_pkg):
  - state enum {IDLE, ITER, DONE};
  - WIDTH default constant;
  - count width = $clog2(WIDTH).
- One combinational sub-module, restoring_step:
  - inputs: R (WIDTH+1), q_msb, D (WIDTH);
  - outputs: R_next, qbit;
  - internally a WIDTH+1-bit ripple subtract built from the existing full-adder cell.
- The top module holds the FSM, counter and registers.

Test Plan:
- Reset, then Dividend=100, Divisor=7, Run=1 -> Busy for 8 cycles; Done on the 9th edge; Quotient=14, Remainder=2, Div_By_Zero=0.
- 255/1 -> Quotient=255, Remainder=0. 5/9 -> Quotient=0, Remainder=5. 255/255 -> Quotient=1, Remainder=0.
- 200/0 -> Done after 9 edges; Quotient=255, Remainder=200, Div_By_Zero=1. A following 10/3 run clears the flag and gives Quotient=3, Remainder=1.
- Run held high through DONE for 20 cycles -> no restart and results stable. Run=0 -> IDLE on the next edge, Done=0. Run=1 again with new operands -> new result.
- Change Dividend/Divisor and toggle Run during ITER (start 100/7) -> result still 14/2.
- Reset at the 4th ITER edge of 100/7 -> next edge IDLE, all outputs 0. Exhaustive random 8-bit pairs are checked against the reference model invariant.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the default width, counter width and FSM state encoding.
package divider_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/restoring_divider_8_bit_restoring_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract
// the divisor with a ripple adder, keep the difference if it is non-negative.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module restoring_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic             qbit
);

    // The stored remainder MSB is always 0 (remainder < divisor),
    // so only the low WIDTH bits are carried between steps.
    logic [WIDTH:0] s;
    logic [WIDTH:0] nd;
    logic [WIDTH:0] t;
    logic [WIDTH:0] c;

    assign s    = {r, q_msb};
    assign nd   = ~{1'b0, d};
    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a   (s[i]),
            .b   (nd[i]),
            .cin (c[i]),
            .sum (t[i]),
            .cout(c[i+1])
        );
    end

    // Top bit needs only the sum; its carry-out has no use.
    assign t[WIDTH] = s[WIDTH] ^ nd[WIDTH] ^ c[WIDTH];

    assign qbit   = ~t[WIDTH];
    assign r_next = qbit ? t[WIDTH-1:0] : s[WIDTH-1:0];

endmodule

// File: rtl/restoring_divider_8_bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Run/Done handshake; constant WIDTH+1 edge latency including divide by 0.
module restoring_divider_8_bit #(
    parameter int WIDTH = divider_pkg::WIDTH
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero
);

    import divider_pkg::*;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;
    logic             dz;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             qbit;

    restoring_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r     (r),
        .q_msb (q[WIDTH-1]),
        .d     (d),
        .r_next(r_step),
        .qbit  (qbit)
    );

    assign q_step = {q[WIDTH-2:0], qbit};

    // State register with reset priority
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Run) state_next = ITER;
            ITER:    if (count == LAST) state_next = DONE;
            DONE:    if (!Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result/handshake registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            dz          <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Div_By_Zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Run) begin
                        d     <= Divisor;
                        q     <= Dividend;
                        r     <= '0;
                        count <= '0;
                        dz    <= (Divisor == '0);
                        Busy  <= 1'b1;
                    end
                end
                ITER: begin
                    r     <= r_step;
                    q     <= q_step;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        Quotient    <= q_step;
                        Remainder   <= r_step;
                        Div_By_Zero <= dz;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                    end
                end
                DONE: begin
                    if (!Run) Done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider_8_bit.sv
// Directed and randomised checks for the restoring divider.
// Expected results are hand values or computed with / and %.
module tb_restoring_divider_8_bit;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic [7:0] Dividend;
    logic [7:0] Divisor;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       Div_By_Zero;

    int checks = 0;
    int errors = 0;

    restoring_divider_8_bit dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Run        (Run),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .Busy       (Busy),
        .Done       (Done),
        .Div_By_Zero(Div_By_Zero)
    );

    always #5 Clk = ~Clk;

    // Return to IDLE, start a divide and count edges until Done (-1 on timeout).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int edges, output int busy_cnt);
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Dividend = a;
        Divisor  = b;
        Run      = 1'b1;
        edges    = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            edges++;
            if (Busy) busy_cnt++;
            if (Done) break;
        end
        if (!Done) edges = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Run   = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (Quotient !== 8'd0) begin
            errors++;
            $display("FAIL reset_quotient: got %0d expected 0", Quotient);
        end
        checks++;
        if (Remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_remainder: got %0d expected 0", Remainder);
        end
        checks++;
        if ({Busy, Done, Div_By_Zero} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {Busy, Done, Div_By_Zero});
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int e, bc;
        run_op(8'd100, 8'd7, e, bc);
        checks++;
        if (e !== 9) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 9", e);
        end
        checks++;
        if (bc !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
        end
        checks++;
        if (Quotient !== 8'd14 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL basic_result: got %0d r %0d expected 14 r 2", Quotient, Remainder);
        end
        checks++;
        if (Div_By_Zero !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got dz %b busy %b expected 0 0", Div_By_Zero, Busy);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'd255, 8'd5, 8'd255};
        logic [7:0] vb [3] = '{8'd1, 8'd9, 8'd255};
        logic [7:0] vq [3] = '{8'd255, 8'd0, 8'd1};
        logic [7:0] vr [3] = '{8'd0, 8'd5, 8'd0};
        int e, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], e, bc);
            checks++;
            if (e !== 9 || Quotient !== vq[i] || Remainder !== vr[i]) begin
                errors++;
                $display("FAIL vector_%0d: got q %0d r %0d edges %0d expected q %0d r %0d edges 9",
                         i, Quotient, Remainder, e, vq[i], vr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int e, bc;
        run_op(8'd200, 8'd0, e, bc);
        checks++;
        if (e !== 9) begin
            errors++;
            $display("FAIL dz_latency: got %0d expected 9", e);
        end
        checks++;
        if (Quotient !== 8'd255 || Remainder !== 8'd200 || Div_By_Zero !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: got q %0d r %0d dz %b expected q 255 r 200 dz 1",
                     Quotient, Remainder, Div_By_Zero);
        end
        run_op(8'd10, 8'd3, e, bc);
        checks++;
        if (Quotient !== 8'd3 || Remainder !== 8'd1 || Div_By_Zero !== 1'b0) begin
            errors++;
            $display("FAIL dz_clear: got q %0d r %0d dz %b expected q 3 r 1 dz 0",
                     Quotient, Remainder, Div_By_Zero);
        end
    endtask

    task automatic test_run_held();
        int e, bc;
        run_op(8'd50, 8'd6, e, bc);
        checks++;
        if (Quotient !== 8'd8 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL held_result: got q %0d r %0d expected q 8 r 2", Quotient, Remainder);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            checks++;
            if (Done !== 1'b1 || Busy !== 1'b0 || Quotient !== 8'd8 || Remainder !== 8'd2) begin
                errors++;
                $display("FAIL held_cycle_%0d: got done %b busy %b q %0d r %0d expected 1 0 8 2",
                         i, Done, Busy, Quotient, Remainder);
            end
        end
        @(negedge Clk);
        Run = 1'b0;
        @(posedge Clk);
        #1;
        checks++;
        if (Done !== 1'b0 || Quotient !== 8'd8 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL held_release: got done %b q %0d r %0d expected 0 8 2",
                     Done, Quotient, Remainder);
        end
        run_op(8'd77, 8'd10, e, bc);
        checks++;
        if (Quotient !== 8'd7 || Remainder !== 8'd7) begin
            errors++;
            $display("FAIL held_rerun: got q %0d r %0d expected q 7 r 7", Quotient, Remainder);
        end
    endtask

    task automatic test_ignore_changes();
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Run      = 1'b1;
        @(posedge Clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Run      = ~Run;
            Dividend = 8'($urandom_range(0, 255));
            Divisor  = 8'($urandom_range(0, 255));
            @(posedge Clk);
            #1;
        end
        checks++;
        if (Done !== 1'b1 || Quotient !== 8'd14 || Remainder !== 8'd2) begin
            errors++;
            $display("FAIL ignore_changes: got done %b q %0d r %0d expected 1 14 2",
                     Done, Quotient, Remainder);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        Run = 1'b0;
        @(negedge Clk);
        Dividend = 8'd100;
        Divisor  = 8'd7;
        Run      = 1'b1;
        @(posedge Clk);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if ({Busy, Done, Div_By_Zero} !== 3'b000 || Quotient !== 8'd0 || Remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy %b done %b dz %b q %0d r %0d expected all 0",
                     Busy, Done, Div_By_Zero, Quotient, Remainder);
        end
        @(posedge Clk);
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold: got busy %b done %b expected 0 0", Busy, Done);
        end
        @(negedge Clk);
        Reset = 1'b0;
        Run   = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] a, b, eq, er;
        int e, bc;
        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            eq = (b == 8'd0) ? 8'd255 : a / b;
            er = (b == 8'd0) ? a : a % b;
            run_op(a, b, e, bc);
            checks++;
            if (e !== 9 || Quotient !== eq || Remainder !== er || Div_By_Zero !== (b == 8'd0)) begin
                errors++;
                $display("FAIL random %0d/%0d: got q %0d r %0d dz %b edges %0d expected q %0d r %0d",
                         a, b, Quotient, Remainder, Div_By_Zero, e, eq, er);
            end
        end
    endtask

    initial begin
        Clk      = 1'b0;
        Reset    = 1'b1;
        Run      = 1'b0;
        Dividend = 8'd0;
        Divisor  = 8'd0;
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_run_held();
        test_ignore_changes();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
